// File: rtl/qos_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qos_stream_arbiter
// Function : Packet-locked N-to-1 stream arbiter, QoS priority (0 = urgent)
//            with round-robin tie-break among equal-rank streams.
// Revision : 1.0
// ============================================================================
module qos_stream_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int QOS_WIDTH    = 4,
  parameter int STREAM_COUNT = 2,
  parameter int ID_WIDTH     = $clog2(STREAM_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [STREAM_COUNT*DATA_WIDTH-1:0]   s_data_i,
  input  logic [STREAM_COUNT*QOS_WIDTH-1:0]    s_qos_i,
  input  logic [STREAM_COUNT-1:0]              s_last_i,
  input  logic [STREAM_COUNT-1:0]              s_valid_i,
  output logic [STREAM_COUNT-1:0]              s_ready_o,
  output logic [DATA_WIDTH-1:0]                m_data_o,
  output logic [QOS_WIDTH-1:0]                 m_qos_o,
  output logic [ID_WIDTH-1:0]                  m_id_o,
  output logic                                 m_last_o,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i
);

  localparam logic [0:0]        c_ST_IDLE = 1'b0;
  localparam logic [0:0]        c_ST_BUSY = 1'b1;
  localparam logic [ID_WIDTH:0] c_STREAMS = (ID_WIDTH+1)'(STREAM_COUNT);

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [QOS_WIDTH-1:0]  r_grant_qos;
  logic [ID_WIDTH-1:0]   r_rr_ptr;

  logic [QOS_WIDTH-1:0]  w_qos  [STREAM_COUNT];
  logic [DATA_WIDTH-1:0] w_data [STREAM_COUNT];

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_win_id;
  logic [QOS_WIDTH-1:0]  w_win_qos;
  logic                  w_g_valid;
  logic                  w_g_last;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic [ID_WIDTH:0]     w_ptr_inc;
  logic [ID_WIDTH-1:0]   w_next_ptr;
  logic                  w_arb_load;
  logic                  w_pkt_done;

  for (genvar g = 0; g < STREAM_COUNT; g++) begin : g_lane
    assign w_qos[g]  = s_qos_i[g*QOS_WIDTH +: QOS_WIDTH];
    assign w_data[g] = s_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // QoS 0 is urgent and beats any nonzero value; otherwise larger wins.
  function automatic logic outranks(input logic [QOS_WIDTH-1:0] a,
                                    input logic [QOS_WIDTH-1:0] b);
    if ((a == '0) != (b == '0)) return (a == '0);
    return (a > b);
  endfunction

  // Strict "outranks" keeps the first equal-rank stream found from r_rr_ptr.
  always_comb begin
    logic [ID_WIDTH:0] idx;
    w_found   = 1'b0;
    w_win_id  = '0;
    w_win_qos = '0;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      idx = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
      if (idx >= c_STREAMS) idx = idx - c_STREAMS;
      if (s_valid_i[idx[ID_WIDTH-1:0]] &&
          (!w_found || outranks(w_qos[idx[ID_WIDTH-1:0]], w_win_qos))) begin
        w_found   = 1'b1;
        w_win_id  = idx[ID_WIDTH-1:0];
        w_win_qos = w_qos[idx[ID_WIDTH-1:0]];
      end
    end
  end

  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      if (r_grant_id == ID_WIDTH'(i)) begin
        w_g_valid = s_valid_i[i];
        w_g_last  = s_last_i[i];
        w_g_data  = w_data[i];
      end
    end
  end

  assign w_ptr_inc  = {1'b0, r_grant_id} + (ID_WIDTH+1)'(1);
  assign w_next_ptr = (w_ptr_inc >= c_STREAMS) ? '0 : w_ptr_inc[ID_WIDTH-1:0];
  assign w_arb_load = (r_state == c_ST_IDLE) && w_found;
  assign w_pkt_done = (r_state == c_ST_BUSY) && w_g_valid && m_ready_i && w_g_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_grant_id  <= '0;
      r_grant_qos <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arb_load) begin
        r_grant_id  <= w_win_id;
        r_grant_qos <= w_win_qos;
      end
      if (w_pkt_done) r_rr_ptr <= w_next_ptr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_found)    w_state_nxt = c_ST_BUSY;
      c_ST_BUSY: if (w_pkt_done) w_state_nxt = c_ST_IDLE;
      default:                   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_last_o  = 1'b0;
    s_ready_o = '0;
    if (r_state == c_ST_BUSY) begin
      m_valid_o = w_g_valid;
      if (w_g_valid) begin
        m_data_o = w_g_data;
        m_last_o = w_g_last;
      end
      for (int i = 0; i < STREAM_COUNT; i++) begin
        s_ready_o[i] = m_ready_i && (r_grant_id == ID_WIDTH'(i));
      end
    end
  end

  assign m_id_o  = r_grant_id;
  assign m_qos_o = r_grant_qos;

endmodule
`default_nettype wire

// File: tb/tb_qos_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_qos_stream_arbiter
// Function : Scoreboard bench: per-stream packet sources, expected beats queued
//            in predicted grant order and matched against accepted output beats.
// Revision : 1.0
// ============================================================================
module tb_qos_stream_arbiter;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int QW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NS*DW-1:0]    s_data_i;
  logic [NS*QW-1:0]    s_qos_i;
  logic [NS-1:0]       s_last_i;
  logic [NS-1:0]       s_valid_i;
  logic [NS-1:0]       s_ready_o;
  logic [DW-1:0]       m_data_o;
  logic [QW-1:0]       m_qos_o;
  logic [IW-1:0]       m_id_o;
  logic                m_last_o;
  logic                m_valid_o;
  logic                m_ready_i;

  qos_stream_arbiter #(
    .DATA_WIDTH(DW), .QOS_WIDTH(QW), .STREAM_COUNT(NS), .ID_WIDTH(IW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_qos_o(m_qos_o), .m_id_o(m_id_o),
    .m_last_o(m_last_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
  );

  logic [DW:0]    src_mem [NS][64];
  int             src_wr  [NS] = '{default: 0};
  int             src_rd  [NS] = '{default: 0};
  logic [QW-1:0]  tb_qos  [NS] = '{default: '0};
  logic [NS-1:0]  tb_stall = '0;
  logic           tb_ready = 1'b0;
  logic [14:0]    exp_q [$];
  int             xfer_cyc [$];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_errors = 0;
  logic [NS-1:0]  hs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_pkt(input int s, input int n, input int base);
    for (int b = 0; b < n; b++) begin
      src_mem[s][src_wr[s] % 64] = {(b == n-1), 8'(base + b)};
      src_wr[s]++;
    end
  endtask

  task automatic expect_pkt(input int s, input int n, input logic [QW-1:0] q, input int base);
    for (int b = 0; b < n; b++) exp_q.push_back({2'(s), q, 8'(base + b), (b == n-1)});
  endtask

  function automatic logic src_empty();
    for (int i = 0; i < NS; i++) if (src_rd[i] < src_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      logic [DW:0] w;
      w = src_mem[i][src_rd[i] % 64];
      if (src_rd[i] < src_wr[i]) begin
        s_valid_i[i]           = !tb_stall[i];
        s_data_i[i*DW +: DW]   = w[DW-1:0];
        s_last_i[i]            = w[DW];
      end else begin
        s_valid_i[i]           = 1'b0;
        s_data_i[i*DW +: DW]   = '0;
        s_last_i[i]            = 1'b0;
      end
      s_qos_i[i*QW +: QW] = tb_qos[i];
    end
    m_ready_i = tb_ready;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !src_empty()) && n < 300) begin
      @(posedge clk);
      n++;
    end
    check_val(tag, exp_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  // Sample just before each rising edge; source pointers advance just after it.
  initial begin : drv
    logic [14:0] e;
    forever begin
      @(negedge clk);
      hs = s_valid_i & s_ready_o;
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_beat", 32'(m_valid_o && m_ready_i), 0);
        end else begin
          e = exp_q.pop_front();
          check_val("beat", {m_id_o, m_qos_o, m_data_o, m_last_o}, e);
          xfer_cyc.push_back(cyc);
        end
      end else if (!m_valid_o) begin
        check_val("idle_zero", {m_data_o, m_last_o}, 0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) if (hs[i]) src_rd[i]++;
      drive_inputs();
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst_n     = 1'b0;
    s_data_i  = '0;
    s_qos_i   = '0;
    s_last_i  = '0;
    s_valid_i = '0;
    m_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", m_valid_o, 0);
    check_val("rst_ready", s_ready_o, 0);
    check_val("rst_id_qos", {m_id_o, m_qos_o}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Warm-up packet moves rr_ptr off zero so reset clearing it is observable.
    @(posedge clk);
    tb_ready  = 1'b1;
    tb_qos[0] = 4'd2;
    add_pkt(0, 1, 'h10);
    expect_pkt(0, 1, 4'd2, 'h10);
    wait_drain("warm_drain");

    tb_ready  = 1'b0;
    tb_qos[2] = 4'd5;
    add_pkt(2, 4, 'h20);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_id", m_id_o, 2);
    check_val("pre_rst_valid", m_valid_o, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("midrst_valid", m_valid_o, 0);
    check_val("midrst_ready", s_ready_o, 0);
    check_val("midrst_id", m_id_o, 0);
    check_val("midrst_qos", m_qos_o, 0);
    check_val("midrst_data_last", {m_data_o, m_last_o}, 0);
    for (int i = 0; i < NS; i++) src_rd[i] = src_wr[i];
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    @(posedge clk);
    tb_ready  = 1'b1;
    tb_qos[0] = 4'd3;
    tb_qos[1] = 4'd3;
    add_pkt(0, 1, 'h30);
    add_pkt(1, 1, 'h31);
    expect_pkt(0, 1, 4'd3, 'h30);
    expect_pkt(1, 1, 4'd3, 'h31);
    wait_drain("rst_drain");

    // Round-robin with single-beat packets: one idle cycle between grants.
    tb_qos[0] = 4'd4;
    tb_qos[1] = 4'd4;
    xfer_cyc.delete();
    add_pkt(0, 1, 'h40);
    add_pkt(1, 1, 'h41);
    add_pkt(0, 1, 'h42);
    add_pkt(1, 1, 'h43);
    expect_pkt(0, 1, 4'd4, 'h40);
    expect_pkt(1, 1, 4'd4, 'h41);
    expect_pkt(0, 1, 4'd4, 'h42);
    expect_pkt(1, 1, 4'd4, 'h43);
    wait_drain("rr_drain");
    check_val("rr_count", xfer_cyc.size(), 4);
    if (xfer_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check_val("rr_gap", xfer_cyc[i] - xfer_cyc[i-1], 2);
    end

    tb_qos[0] = 4'd2;
    tb_qos[1] = 4'd7;
    tb_qos[2] = 4'd5;
    tb_qos[3] = 4'd0;
    add_pkt(0, 2, 'h50);
    add_pkt(1, 2, 'h60);
    add_pkt(2, 2, 'h70);
    add_pkt(3, 2, 'h80);
    expect_pkt(3, 2, 4'd0, 'h80);
    expect_pkt(1, 2, 4'd7, 'h60);
    expect_pkt(2, 2, 4'd5, 'h70);
    expect_pkt(0, 2, 4'd2, 'h50);
    wait_drain("prio_drain");

    // Urgent arrival and QoS change mid-packet must not break the grant.
    tb_qos[0] = 4'd3;
    add_pkt(0, 4, 'h90);
    expect_pkt(0, 4, 4'd3, 'h90);
    repeat (3) @(posedge clk);
    tb_qos[0] = 4'd9;
    tb_qos[1] = 4'd0;
    add_pkt(1, 1, 'hA0);
    expect_pkt(1, 1, 4'd0, 'hA0);
    wait_drain("lock_drain");

    tb_ready  = 1'b0;
    tb_qos[2] = 4'd6;
    tb_qos[3] = 4'd1;
    add_pkt(2, 3, 'hB0);
    add_pkt(3, 1, 'hC0);
    expect_pkt(2, 3, 4'd6, 'hB0);
    expect_pkt(3, 1, 4'd1, 'hC0);
    repeat (2) @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check_val("bp_id", m_id_o, 2);
      check_val("bp_ready", s_ready_o, 0);
      check_val("bp_valid", m_valid_o, 1);
    end
    @(posedge clk);
    tb_ready    = 1'b1;
    tb_stall[2] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_val("stall_valid", m_valid_o, 0);
      check_val("stall_ready", s_ready_o, 4'b0100);
      check_val("stall_id", m_id_o, 2);
    end
    @(posedge clk);
    tb_stall = '0;
    wait_drain("bp_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qos_stream_arbiter.md
# qos_stream_arbiter

Packet-aware N-to-1 stream arbiter with QoS priority and round-robin tie-break. It selects one of `STREAM_COUNT` valid/ready input streams by QoS value, locks the grant for a whole packet (until the `last` beat is accepted), and forwards it to a single output stream tagged with the winning stream ID and QoS. It sits between the per-source stream interfaces and the shared downstream sink, and replaces the combinational ID selector with a registered, handshake-correct block.

## Interface
- `DATA_WIDTH`, 8, payload width per beat
- `QOS_WIDTH`, 4, QoS field width
- `STREAM_COUNT`, 2, number of input streams (legal range ≥ 2)
- `ID_WIDTH`, `$clog2(STREAM_COUNT)`, stream ID width
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `s_data_i`  in  `[DATA_WIDTH-1:0]` × `STREAM_COUNT`  per-stream payload
- `s_qos_i`  in  `[QOS_WIDTH-1:0]` × `STREAM_COUNT`  per-stream QoS
- `s_last_i`  in  `STREAM_COUNT`  per-stream end-of-packet flag
- `s_valid_i`  in  `STREAM_COUNT`  per-stream valid
- `s_ready_o`  out  `STREAM_COUNT`  per-stream ready
- `m_data_o`  out  `DATA_WIDTH`  forwarded payload
- `m_qos_o`  out  `QOS_WIDTH`  QoS latched at arbitration
- `m_id_o`  out  `ID_WIDTH`  granted stream index
- `m_last_o`  out  1  forwarded end-of-packet flag
- `m_valid_o`  out  1  output valid
- `m_ready_i`  in  1  downstream ready

## Operation
- Two-state FSM: IDLE, BUSY. A beat transfers on any port when valid and ready are both high in the same cycle.
- Priority rank: a valid stream with QoS == 0 is urgent and outranks every nonzero QoS. Among nonzero values, higher QoS wins.
- Ties between equal-rank streams go round-robin. The search starts at `rr_ptr` and increments modulo `STREAM_COUNT`. The first equal-rank stream found wins.
- IDLE: when any `s_valid_i` is high, register the winner into `grant_id` and its QoS into `grant_qos`, then go to BUSY. No `s_ready_o` is asserted in IDLE.
- BUSY:
  - `m_valid_o` = `s_valid_i[grant_id]`.
  - `m_data_o` and `m_last_o` are taken from stream `grant_id`.
  - `s_ready_o[grant_id]` = `m_ready_i`; all other `s_ready_o` bits are 0.
- BUSY exit: on a transfer with `s_last_i[grant_id]`=1, set `rr_ptr` to `grant_id+1`, wrapping to 0 at `STREAM_COUNT`, and return to IDLE.
- The grant is held for the whole packet:
  - QoS changes and higher-priority arrivals mid-packet are ignored.
  - If the granted source drops valid mid-packet, the output stalls (`m_valid_o`=0) and the grant is kept.
- `m_qos_o` and `m_id_o` hold the latched grant values for the whole packet.
- When `m_valid_o`=0, `m_data_o` and `m_last_o` are driven to 0.

## Timing
- Reset (`rst_n`=0, asynchronous, at any time including mid-packet) forces:
  - state IDLE, `rr_ptr`=0, `grant_id`=0, `grant_qos`=0;
  - outputs `m_valid_o`=0, `s_ready_o`=0, `m_id_o`=0, `m_qos_o`=0, `m_data_o`=0, `m_last_o`=0.
- No partial packet survives reset. After `rst_n` rises, arbitration restarts from `rr_ptr`=0.
- Arbitration latency: a valid seen in IDLE at cycle t gives `m_valid_o` at t+1. The first beat can transfer at t+1.
- Throughput in BUSY: one beat per cycle, zero added latency. The ready/valid paths are combinational through the granted lane.
- Packet gap: one IDLE cycle between packets, so a stream can have at most one packet per (length+1) cycles.
- Single-beat packet: `s_last_i`=1 on the first beat gives BUSY for exactly the transfer cycle(s), then IDLE.
- `m_ready_i` low in BUSY: nothing transfers, the grant holds, and `m_*` stay stable because sources are expected to hold their data.
- Simultaneous last-transfer and a new valid from another stream: that stream is arbitrated in the following IDLE cycle using the updated `rr_ptr`.

## Test plan
- Reset: assert `rst_n`=0 mid-packet -> all outputs 0 immediately. After release, valid on streams 0 and 1 with QoS 3 and 3 -> `m_id_o`=0.
- Priority: `STREAM_COUNT`=4, QoS {2,7,5,0}, all valid -> grant 3 (urgent). After its last beat, QoS {2,7,5,-} -> grant 1.
- Round-robin: streams 0 and 1 both QoS 4 and always valid, single-beat packets -> grants alternate 0,1,0,1 with one idle cycle between packets.
- Packet lock: grant stream 0 with a 4-beat packet; at beat 2 raise stream 1 to QoS 0 -> all 4 beats come from `m_id_o`=0, then stream 1 is granted.
- Backpressure and source stall: hold `m_ready_i`=0 for 3 cycles, then drop the granted `s_valid_i` for 2 cycles -> no transfers, no lost or duplicated beats, grant unchanged, `s_ready_o` of other streams stays 0.
